mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares port B of the unified instruction/data BRAM between two requesters:
//   - M0: riscv_core load/store traffic.
//   - M1: a boot/debug loader (UART or JTAG bridge) that writes program images.
//  Sits between the requesters and the memory; the memory's port A (instruction fetch) is untouched.
//  Tracks in-flight reads through the fixed BRAM read latency and returns each read to its issuer.
// PARAMETERS
//  AW        13  word-address width (32 KiB memory)
//  DW        32  data width
//  RD_LAT     2  memory read latency in cycles (BRAM + output register, regce=1)
// PORTS
//  clk_i        in   1      system clock
//  rst_i        in   1      synchronous reset, active-high
//  m0_req_i     in   1      core request valid
//  m0_we_i      in   4      core byte write enables (0 = read)
//  m0_addr_i    in   AW     core word address
//  m0_wdata_i   in   DW     core write data
//  m0_gnt_o     out  1      core request accepted this cycle
//  m0_rvalid_o  out  1      core read data valid
//  m0_rdata_o   out  DW     core read data
//  m0_stall_o   out  1      m0_req_i & ~m0_gnt_o (core pipeline stall)
//  m1_req_i / m1_we_i / m1_addr_i / m1_wdata_i / m1_gnt_o / m1_rvalid_o / m1_rdata_o
//               same as M0, for the loader
//  m1_lock_i    in   1      loader holds ownership across consecutive beats
//  mem_en_o     out  1      memory port enable (= any grant)
//  mem_we_o     out  4      memory byte write enables
//  mem_addr_o   out  AW     memory word address
//  mem_din_o    out  DW     memory write data
//  mem_dout_i   in   DW     memory read data
// BEHAVIOUR
//  - Reset: owner=NONE, all gnt/rvalid=0, rdata=0, read-tag pipeline cleared.
//    Reads in flight at reset are discarded; no rvalid follows them.
//  - Grant is combinational from the current req and the registered state:
//    - At most one gnt per cycle.
//    - The granted master's we/addr/wdata drive mem_* the same cycle.
//    - When no gnt: mem_we_o=0 and mem_en_o=0.
//  - FSM (registered owner):
//    - ARB: pick per the priority policy.
//      - Granting M1 with m1_lock_i=1 moves to LOCK_M1.
//    - LOCK_M1: only M1 may be granted; M0 stalls.
//      - Returns to ARB on the first cycle m1_lock_i=0 (that cycle is still arbitrated as ARB).
//  - Fixed priority (default): M0 > M1. M1 is granted only when M0 has no request.
//  - Read return:
//    - Each granted read (we==0) pushes a tag {valid,id} into an RD_LAT-deep shift register.
//    - At the tail: rvalid of the tagged master pulses for 1 cycle; rdata_o captures mem_dout_i.
//    - Read latency from gnt to rvalid is exactly RD_LAT cycles, back-to-back without bubbles.
//    - Writes generate no rvalid.
//  - rdata of the non-selected master holds its last value.
//  - Simultaneous M0 and M1 requests in ARB resolve per policy; the loser keeps req and waits.
//  - A requester must hold req/we/addr/wdata stable until gnt.
//  - A lock asserted while M0 holds a pending request takes effect only after M1 is next granted.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN:
//   - Defined: 1-bit last-grant pointer. When both request in ARB, grant the master not granted last.
//     The pointer updates on every grant and resets to M1, so M0 wins the first tie.
//   - Undefined: fixed priority M0 > M1; pointer logic absent.
// STRUCTURE
//  - Package riscv_mem_pkg:
//    - typedef enum {OWN_ARB, OWN_LOCK_M1} arb_state_e
//    - typedef enum logic {MST_CORE, MST_LOADER} mst_id_e
//    - typedef struct packed {logic valid; mst_id_e id;} rd_tag_t
//    - localparam MEM_AW = 13
//  - Sub-module rd_tag_pipe: parameterised RD_LAT shift register of rd_tag_t with synchronous clear.
// TESTING
//  1. Reset mid-read:
//     - Stimulus: M0 read at 0x010; assert rst_i 1 cycle later.
//     - Required: no m0_rvalid_o ever; all outputs 0 after reset.
//  2. Single read:
//     - Stimulus: preload mem[0x004]=32'hDEADBEEF; M0 read at 0x004.
//     - Required: gnt same cycle; m0_rvalid_o exactly 2 cycles later with rdata=32'hDEADBEEF.
//  3. Collision, fixed priority:
//     - Stimulus: M0 and M1 both request at cycle 0.
//     - Required: M0 granted at cycle 0, M1 at cycle 1; m0_stall_o=0 throughout.
//  4. Lock:
//     - Stimulus: M1 writes 4 beats with m1_lock_i=1 (0x100..0x103 = 1..4); M0 requests at beat 2.
//     - Required: M0 stalls until lock drops, then is granted; readback of 0x102 returns 3.
//  5. Back-to-back reads:
//     - Stimulus: M0 and M1 alternate reads every cycle.
//     - Required: each rvalid goes to the correct master at gnt+RD_LAT, no drops, no swaps.
//  6. Round robin (with ARB_ROUND_ROBIN_EN):
//     - Stimulus: M0 and M1 both request continuously for 6 cycles.
//     - Required: grants M0,M1,M0,M1,M0,M1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// riscv_mem_pkg: shared types and sizes for the BRAM port-B arbiter.
package riscv_mem_pkg;
    localparam int MEM_AW = 13;
    localparam int MEM_DW = 32;
    localparam int MEM_RD_LAT = 2;
    typedef enum logic {OWN_ARB, OWN_LOCK_M1} arb_state_e;
    typedef enum logic {MST_CORE, MST_LOADER} mst_id_e;
    typedef struct packed {logic valid; mst_id_e id;} rd_tag_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core (m0), loader (m1) and memory port-B signals.
interface mem_port_arbiter_if import riscv_mem_pkg::*; #(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
);
    logic          m0_req_i;
    logic [3:0]    m0_we_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_wdata_i;
    logic          m0_gnt_o;
    logic          m0_rvalid_o;
    logic [DW-1:0] m0_rdata_o;
    logic          m0_stall_o;
    logic          m1_req_i;
    logic [3:0]    m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_wdata_i;
    logic          m1_gnt_o;
    logic          m1_rvalid_o;
    logic [DW-1:0] m1_rdata_o;
    logic          m1_lock_i;
    logic          mem_en_o;
    logic [3:0]    mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_din_o;
    logic [DW-1:0] mem_dout_i;
    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_lock_i, mem_dout_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_stall_o,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_din_o
    );
    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_lock_i, mem_dout_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_stall_o,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_din_o
    );
endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: LAT-deep shift register carrying read tags through the BRAM latency.
module rd_tag_pipe import riscv_mem_pkg::*; #(
    parameter int LAT = MEM_RD_LAT
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);
    rd_tag_t r_pipe [LAT];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < LAT; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[0] <= i_tag;
            for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end
    assign o_tag = r_pipe[LAT-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares BRAM port B between core (m0) and loader (m1), routing reads back.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed m0 > m1 priority.
module mem_port_arbiter import riscv_mem_pkg::*; #(
    parameter int RD_LAT = MEM_RD_LAT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.slave  io_bus
);
    arb_state_e      r_state, w_state_nxt;
    logic            w_lock_act, w_m0_wins, w_gnt0, w_gnt1, w_ret0, w_ret1;
    rd_tag_t         w_tag_in, w_tag_out;
    logic [MEM_DW-1:0] r_rdata0, r_rdata1;
`ifdef ARB_ROUND_ROBIN_EN
    mst_id_e r_last;
    always_ff @(posedge clk_i) begin
        if (rst_i) r_last <= MST_LOADER;
        else if (w_gnt0 || w_gnt1) r_last <= w_gnt1 ? MST_LOADER : MST_CORE;
    end
    assign w_m0_wins = r_last == MST_LOADER;
`else
    assign w_m0_wins = 1'b1;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= OWN_ARB;
        else r_state <= w_state_nxt;
    end
    // A lock-holding cycle with m1_lock_i low is already arbitrated as ARB.
    always_comb begin
        w_lock_act  = r_state == OWN_LOCK_M1 && io_bus.m1_lock_i;
        w_gnt0      = !rst_i && !w_lock_act && io_bus.m0_req_i && (!io_bus.m1_req_i || w_m0_wins);
        w_gnt1      = !rst_i && io_bus.m1_req_i && !w_gnt0;
        w_state_nxt = io_bus.m1_lock_i && (r_state == OWN_LOCK_M1 || w_gnt1) ? OWN_LOCK_M1 : OWN_ARB;
    end
    assign io_bus.m0_gnt_o   = w_gnt0;
    assign io_bus.m1_gnt_o   = w_gnt1;
    assign io_bus.m0_stall_o = io_bus.m0_req_i && !w_gnt0;
    assign io_bus.mem_en_o   = w_gnt0 || w_gnt1;
    assign io_bus.mem_we_o   = w_gnt0 ? io_bus.m0_we_i : w_gnt1 ? io_bus.m1_we_i : 4'b0;
    assign io_bus.mem_addr_o = w_gnt1 ? io_bus.m1_addr_i : io_bus.m0_addr_i;
    assign io_bus.mem_din_o  = w_gnt1 ? io_bus.m1_wdata_i : io_bus.m0_wdata_i;
    assign w_tag_in = '{valid: (w_gnt0 && io_bus.m0_we_i == 4'b0) || (w_gnt1 && io_bus.m1_we_i == 4'b0),
                        id: w_gnt1 ? MST_LOADER : MST_CORE};
    rd_tag_pipe #(.LAT(RD_LAT)) u_tags (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );
    assign w_ret0 = !rst_i && w_tag_out.valid && w_tag_out.id == MST_CORE;
    assign w_ret1 = !rst_i && w_tag_out.valid && w_tag_out.id == MST_LOADER;
    assign io_bus.m0_rvalid_o = w_ret0;
    assign io_bus.m1_rvalid_o = w_ret1;
    assign io_bus.m0_rdata_o  = w_ret0 ? io_bus.mem_dout_i : r_rdata0;
    assign io_bus.m1_rdata_o  = w_ret1 ? io_bus.mem_dout_i : r_rdata1;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_ret0) r_rdata0 <= io_bus.mem_dout_i;
            if (w_ret1) r_rdata1 <= io_bus.mem_dout_i;
        end
    end
endmodule
